uart_cmd_ctrl: RTL and testbench

Command sequencer between the UART byte receiver and the TCS3200 colour-measurement core.
- Consumes the receiver's byte stream (rx_msg plus a 1-cycle rx_complete strobe) and parses fixed 4-byte command frames.
- Applies the decoded settings to the sensor configuration registers and issues single-measurement start pulses.
- Returns a 1-byte ACK/NACK through a valid/ready handshake to the transmit path.

---
 rtl/uart_cmd_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer between the UART byte receiver and the
// TCS3200 colour-measurement core. Parses 4-byte frames (HDR, CMD, ARG, TERM),
// applies settings to the sensor configuration registers, fires single
// measurement pulses and returns a 1-byte ACK/NACK over a valid/ready handshake.
//
// Optional feature: define CMD_READBACK_EN to add the 'R' readback command.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a header byte, everything else dropped
// CMD   | header seen, waiting for the command byte
// ARG   | command latched, waiting for the argument byte
// TERM  | argument latched, waiting for the terminator
// EXEC  | one cycle: decode command, update config, build response
// RESP  | response held until the transmit path accepts it

module uart_cmd_ctrl #(
  parameter logic [7:0] HDR_BYTE       = 8'h43,
  parameter logic [7:0] TERM_BYTE      = 8'h23,
  parameter int         TIMEOUT_CYCLES = 1540,
  parameter logic [7:0] PERIOD_RST     = 8'd10
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic [7:0] rx_msg,
  input  logic       rx_complete,
  output logic [1:0] cfg_filter,
  output logic       cfg_scan_en,
  output logic [7:0] cfg_period,
  output logic       meas_start,
  output logic       resp_valid,
  output logic [7:0] resp_code,
  input  logic       resp_ready,
  output logic       busy
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] PARITY_ERR = 8'h3F;
  localparam logic [7:0] CODE_ACK   = 8'h41;
  localparam logic [7:0] CODE_NACK  = 8'h4E;
  localparam logic [7:0] CMD_FILTER = 8'h46;
  localparam logic [7:0] CMD_SCAN   = 8'h45;
  localparam logic [7:0] CMD_PERIOD = 8'h50;
  localparam logic [7:0] CMD_START  = 8'h53;
`ifdef CMD_READBACK_EN
  localparam logic [7:0] CMD_READ   = 8'h52;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ARG,
    S_TERM,
    S_EXEC,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   w_timer_nxt;
  logic [7:0]           r_cmd;
  logic [7:0]           w_cmd_nxt;
  logic [7:0]           r_arg;
  logic [7:0]           w_arg_nxt;
  logic [1:0]           r_filter;
  logic [1:0]           w_filter_nxt;
  logic                 r_scan_en;
  logic                 w_scan_en_nxt;
  logic [7:0]           r_period;
  logic [7:0]           w_period_nxt;
  logic                 r_meas_start;
  logic                 w_meas_start_nxt;
  logic                 r_resp_valid;
  logic                 w_resp_valid_nxt;
  logic [7:0]           r_resp_code;
  logic [7:0]           w_resp_code_nxt;
  logic                 r_busy;

  // State register.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, frame parsing, command decode and next values of all outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_cmd_nxt        = r_cmd;
    w_arg_nxt        = r_arg;
    w_filter_nxt     = r_filter;
    w_scan_en_nxt    = r_scan_en;
    w_period_nxt     = r_period;
    w_meas_start_nxt = 1'b0;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_code_nxt  = r_resp_code;

    case (r_state)
      S_IDLE: begin
        if (rx_complete && (rx_msg == HDR_BYTE)) begin
          w_state_nxt = S_CMD;
          w_timer_nxt = '0;
        end
      end

      S_CMD, S_ARG, S_TERM: begin
        // A byte arriving on the timeout cycle still counts.
        if (rx_complete) begin
          w_timer_nxt = '0;
          if (rx_msg == PARITY_ERR) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_code_nxt  = CODE_NACK;
          end else if (r_state == S_CMD) begin
            w_cmd_nxt   = rx_msg;
            w_state_nxt = S_ARG;
          end else if (r_state == S_ARG) begin
            w_arg_nxt   = rx_msg;
            w_state_nxt = S_TERM;
          end else if (rx_msg == TERM_BYTE) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_code_nxt  = CODE_NACK;
          end
        end else if (r_timer == TIMER_LAST) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_EXEC: begin
        w_state_nxt      = S_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_code_nxt  = CODE_NACK;
        case (r_cmd)
          CMD_FILTER: begin
            if (r_arg <= 8'd3) begin
              w_filter_nxt    = r_arg[1:0];
              w_resp_code_nxt = CODE_ACK;
            end
          end
          CMD_SCAN: begin
            if (r_arg[7:1] == 7'd0) begin
              w_scan_en_nxt   = r_arg[0];
              w_resp_code_nxt = CODE_ACK;
            end
          end
          CMD_PERIOD: begin
            if (r_arg != 8'd0) begin
              w_period_nxt    = r_arg;
              w_resp_code_nxt = CODE_ACK;
            end
          end
          CMD_START: begin
            // A single shot would collide with the scan engine, so refuse it.
            if (!r_scan_en) begin
              w_meas_start_nxt = 1'b1;
              w_resp_code_nxt  = CODE_ACK;
            end
          end
`ifdef CMD_READBACK_EN
          CMD_READ: begin
            if (r_arg == 8'd0) begin
              w_resp_code_nxt = {5'b0, r_scan_en, r_filter};
            end else if (r_arg == 8'd1) begin
              w_resp_code_nxt = r_period;
            end
          end
`endif
          default: begin
          end
        endcase
      end

      S_RESP: begin
        if (resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      r_timer      <= '0;
      r_cmd        <= 8'h00;
      r_arg        <= 8'h00;
      r_filter     <= 2'b00;
      r_scan_en    <= 1'b0;
      r_period     <= PERIOD_RST;
      r_meas_start <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_code  <= 8'h00;
      r_busy       <= 1'b0;
    end else begin
      r_timer      <= w_timer_nxt;
      r_cmd        <= w_cmd_nxt;
      r_arg        <= w_arg_nxt;
      r_filter     <= w_filter_nxt;
      r_scan_en    <= w_scan_en_nxt;
      r_period     <= w_period_nxt;
      r_meas_start <= w_meas_start_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_code  <= w_resp_code_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign cfg_filter  = r_filter;
  assign cfg_scan_en = r_scan_en;
  assign cfg_period  = r_period;
  assign meas_start  = r_meas_start;
  assign resp_valid  = r_resp_valid;
  assign resp_code   = r_resp_code;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: directed frames from the test plan plus a
// randomized frame stream, checked against a frame-level reference model.
`timescale 1ns/1ps

module tb_uart_cmd_ctrl;

  logic       clk_3125;
  logic       rst_n;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic [1:0] cfg_filter;
  logic       cfg_scan_en;
  logic [7:0] cfg_period;
  logic       meas_start;
  logic       resp_valid;
  logic [7:0] resp_code;
  logic       resp_ready;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int meas_cnt = 0;

  // Reference model state (frame level)
  logic [1:0] m_filter;
  logic       m_scan;
  logic [7:0] m_period;

  uart_cmd_ctrl dut (
    .clk_3125   (clk_3125),
    .rst_n      (rst_n),
    .rx_msg     (rx_msg),
    .rx_complete(rx_complete),
    .cfg_filter (cfg_filter),
    .cfg_scan_en(cfg_scan_en),
    .cfg_period (cfg_period),
    .meas_start (meas_start),
    .resp_valid (resp_valid),
    .resp_code  (resp_code),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  initial clk_3125 = 1'b0;
  always #160 clk_3125 = ~clk_3125;

  always @(posedge clk_3125) begin
    if (rst_n && meas_start) meas_cnt <= meas_cnt + 1;
  end

  initial begin
    #(40_000_000);
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Caller is at a negedge; the strobe is sampled at the following posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_msg      = b;
    rx_complete = 1'b1;
    @(negedge clk_3125);
    rx_complete = 1'b0;
  endtask

  task automatic model_reset();
    m_filter = 2'b00;
    m_scan   = 1'b0;
    m_period = 8'd10;
  endtask

  task automatic chk_cfg(input string tag);
    chk({tag, ".filter"}, 32'(cfg_filter), 32'(m_filter));
    chk({tag, ".scan"},   32'(cfg_scan_en), 32'(m_scan));
    chk({tag, ".period"}, 32'(cfg_period), 32'(m_period));
  endtask

  // Sends header then c,a,t (stopping after a parity-error byte), predicts
  // the outcome from the frame rules, then drains the response.
  task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] t,
                           input int hold, input int gap_max);
    logic [7:0] b [3];
    int         nb;
    logic       bad;
    logic [7:0] e_code;
    int         e_lat;
    int         e_meas;
    int         lat;
    int         mc0;
    b[0] = c; b[1] = a; b[2] = t;
    nb = 3;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!bad && b[i] == 8'h3F) begin
        bad = 1'b1;
        nb  = i + 1;
      end
    end
    e_meas = 0;
    e_lat  = 0;
    e_code = 8'h4E;
    if (!bad && t == 8'h23) begin
      e_lat = 1;
      case (c)
        8'h46: if (a <= 8'd3) begin m_filter = a[1:0]; e_code = 8'h41; end
        8'h45: if (a <= 8'd1) begin m_scan = a[0]; e_code = 8'h41; end
        8'h50: if (a != 8'd0) begin m_period = a; e_code = 8'h41; end
        8'h53: if (!m_scan) begin e_meas = 1; e_code = 8'h41; end
`ifdef CMD_READBACK_EN
        8'h52: begin
          if (a == 8'd0) e_code = {5'b0, m_scan, m_filter};
          else if (a == 8'd1) e_code = m_period;
        end
`endif
        default: e_code = 8'h4E;
      endcase
    end

    mc0 = meas_cnt;
    resp_ready = (hold == 0);
    send_byte(8'h43);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge clk_3125);
      send_byte(b[i]);
    end
    lat = 0;
    while (!resp_valid && lat < 4) begin
      @(negedge clk_3125);
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_code", 32'(resp_code), 32'(e_code));
    chk("busy_resp", 32'(busy), 32'd1);
    chk_cfg("cfg");
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        if (k == 1) send_byte(8'h43);
        else @(negedge clk_3125);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_code", 32'(resp_code), 32'(e_code));
      end
      resp_ready = 1'b1;
    end
    @(negedge clk_3125);
    chk("valid_clear", 32'(resp_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    resp_ready = 1'b0;
    @(negedge clk_3125);
    chk("meas_pulses", 32'(meas_cnt - mc0), 32'(e_meas));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".filter"}, 32'(cfg_filter), 32'd0);
    chk({tag, ".scan"},   32'(cfg_scan_en), 32'd0);
    chk({tag, ".period"}, 32'(cfg_period), 32'd10);
    chk({tag, ".meas"},   32'(meas_start), 32'd0);
    chk({tag, ".valid"},  32'(resp_valid), 32'd0);
    chk({tag, ".code"},   32'(resp_code), 32'd0);
    chk({tag, ".busy"},   32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] cmds [6];
    logic [7:0] c, a, t;
    cmds[0] = 8'h46; cmds[1] = 8'h45; cmds[2] = 8'h50;
    cmds[3] = 8'h53; cmds[4] = 8'h52; cmds[5] = 8'h00;

    rst_n       = 1'b0;
    rx_msg      = 8'h00;
    rx_complete = 1'b0;
    resp_ready  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_3125);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_3125);

    // Directed test-plan frames
    run_frame(8'h46, 8'h02, 8'h23, 0, 0);
    run_frame(8'h46, 8'h05, 8'h23, 0, 2);
    run_frame(8'h50, 8'h00, 8'h23, 2, 0);
    run_frame(8'h53, 8'h00, 8'h23, 0, 0);
    run_frame(8'h45, 8'h01, 8'h23, 0, 0);
    run_frame(8'h53, 8'h00, 8'h23, 0, 0);
    run_frame(8'h3F, 8'h00, 8'h00, 0, 0);
    run_frame(8'h46, 8'h01, 8'h24, 0, 0);
    run_frame(8'h43, 8'h01, 8'h23, 0, 0);
    run_frame(8'h45, 8'h00, 8'h23, 50, 0);

    // Timeout: header + command then silence
    send_byte(8'h43);
    send_byte(8'h46);
    repeat (1539) @(negedge clk_3125);
    chk("to_busy_before", 32'(busy), 32'd1);
    @(negedge clk_3125);
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_no_resp", 32'(resp_valid), 32'd0);
    repeat (5) @(negedge clk_3125);
    chk("to_still_quiet", 32'(resp_valid), 32'd0);

    // A byte on the timeout cycle wins
    send_byte(8'h43);
    repeat (1539) @(negedge clk_3125);
    send_byte(8'h46);
    chk("to_edge_busy", 32'(busy), 32'd1);
    send_byte(8'h03);
    send_byte(8'h23);
    m_filter = 2'b11;
    repeat (2) @(negedge clk_3125);
    chk("to_edge_valid", 32'(resp_valid), 32'd1);
    chk("to_edge_code", 32'(resp_code), 32'h41);
    chk_cfg("to_edge");
    resp_ready = 1'b1;
    @(negedge clk_3125);
    resp_ready = 1'b0;
    chk("to_edge_clear", 32'(resp_valid), 32'd0);

    // Reset mid-frame
    run_frame(8'h50, 8'h21, 8'h23, 0, 0);
    send_byte(8'h43);
    send_byte(8'h46);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    model_reset();
    @(negedge clk_3125);
    rst_n = 1'b1;
    @(negedge clk_3125);
    run_frame(8'h52, 8'h01, 8'h23, 0, 0);

    // Randomized frame stream
    for (int n = 0; n < 80; n++) begin
      c = cmds[$urandom_range(5, 0)];
      if (c == 8'h00) c = 8'($urandom);
      a = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(4, 0));
      t = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'h23;
      if ($urandom_range(9, 0) == 0) begin
        case ($urandom_range(2, 0))
          0: c = 8'h3F;
          1: a = 8'h3F;
          default: t = 8'h3F;
        endcase
      end
      run_frame(c, a, t, $urandom_range(6, 0), 4);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
